// File: rtl/projector_interface.sv
// Point-rate front end: turns update strobes into registered X/Y DAC codes,
// laser colour and a one-cycle DAC start pulse, from a stream or a test square.
module projector_interface #(
    parameter logic [11:0] CENTER    = 12'h800,
    parameter logic [11:0] PAT_MIN   = 12'h400,
    parameter logic [11:0] PAT_STEP  = 12'h100,
    parameter int unsigned PAT_STEPS = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        update,
    input  logic [31:0] data_in,
    input  logic [1:0]  control,
    output logic        frame_done,
    output logic [11:0] DAC_x,
    output logic [11:0] DAC_y,
    output logic        DAC_start,
    output logic [2:0]  laser_rgb
);

    localparam int unsigned COORD_W = 12;
    localparam int unsigned IDX_W   = 5;

    localparam logic [COORD_W-1:0] PAT_MAX = PAT_MIN + COORD_W'(PAT_STEPS) * PAT_STEP;

    localparam logic [1:0] MODE_PARK  = 2'd0;
    localparam logic [1:0] MODE_PAT   = 2'd2;
    localparam logic [1:0] MODE_BLANK = 2'd3;

    localparam logic [IDX_W-1:0] LAST_IDX = 5'd31;

    localparam logic [2:0] RGB_RED   = 3'b100;
    localparam logic [2:0] RGB_GREEN = 3'b010;
    localparam logic [2:0] RGB_BLUE  = 3'b001;
    localparam logic [2:0] RGB_WHITE = 3'b111;

    logic               r_update_q;
    logic [IDX_W-1:0]   r_idx;
    logic [COORD_W-1:0] r_x;
    logic [COORD_W-1:0] r_y;
    logic [2:0]         r_rgb;
    logic               r_start;
    logic               r_frame_done;

    logic               w_tick;
    logic [2:0]         w_k;
    logic [1:0]         w_e;
    logic [COORD_W-1:0] w_off;
    logic [COORD_W-1:0] w_pat_x;
    logic [COORD_W-1:0] w_pat_y;
    logic [2:0]         w_pat_rgb;
    logic               w_unused_bits;

    // Stream bits [30:27] carry nothing for this block.
    assign w_unused_bits = &{1'b0, data_in[30:27]};

    assign w_tick = update & ~r_update_q;

    // Test-square point for the current index: edge selects side and colour.
    always_comb begin
        w_k       = r_idx[2:0];
        w_e       = r_idx[4:3];
        w_off     = COORD_W'({9'd0, w_k}) * PAT_STEP;
        w_pat_x   = PAT_MIN;
        w_pat_y   = PAT_MIN;
        w_pat_rgb = RGB_RED;
        case (w_e)
            2'd0: begin
                w_pat_x   = PAT_MIN + w_off;
                w_pat_y   = PAT_MIN;
                w_pat_rgb = RGB_RED;
            end
            2'd1: begin
                w_pat_x   = PAT_MAX;
                w_pat_y   = PAT_MIN + w_off;
                w_pat_rgb = RGB_GREEN;
            end
            2'd2: begin
                w_pat_x   = PAT_MAX - w_off;
                w_pat_y   = PAT_MAX;
                w_pat_rgb = RGB_BLUE;
            end
            default: begin
                w_pat_x   = PAT_MIN;
                w_pat_y   = PAT_MAX - w_off;
                w_pat_rgb = RGB_WHITE;
            end
        endcase
    end

    // Point register: loads a new point on each update rising edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_update_q   <= 1'b0;
            r_idx        <= '0;
            r_x          <= CENTER;
            r_y          <= CENTER;
            r_rgb        <= 3'b000;
            r_start      <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_update_q   <= update;
            r_start      <= 1'b0;
            r_frame_done <= 1'b0;
            // Leaving pattern mode at any time rewinds the square.
            if (control != MODE_PAT) begin
                r_idx <= '0;
            end
            if (w_tick) begin
                case (control)
                    MODE_PARK: begin
                        r_x   <= CENTER;
                        r_y   <= CENTER;
                        r_rgb <= 3'b000;
                    end
                    MODE_PAT: begin
                        r_x          <= w_pat_x;
                        r_y          <= w_pat_y;
                        r_rgb        <= w_pat_rgb;
                        r_start      <= 1'b1;
                        r_frame_done <= (r_idx == LAST_IDX);
                        r_idx        <= r_idx + 5'd1;
                    end
                    default: begin
                        r_x          <= data_in[11:0];
                        r_y          <= data_in[23:12];
                        r_rgb        <= (control == MODE_BLANK) ? 3'b000 : data_in[26:24];
                        r_start      <= 1'b1;
                        r_frame_done <= data_in[31];
                    end
                endcase
            end
        end
    end

    assign DAC_x      = r_x;
    assign DAC_y      = r_y;
    assign laser_rgb  = r_rgb;
    assign DAC_start  = r_start;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_projector_interface.sv
// Directed bench for projector_interface: vector table plus corner sequences.
module tb_projector_interface;

    logic        clk;
    logic        reset;
    logic        update;
    logic [31:0] data_in;
    logic [1:0]  control;
    logic        frame_done;
    logic [11:0] DAC_x;
    logic [11:0] DAC_y;
    logic        DAC_start;
    logic [2:0]  laser_rgb;

    int n_cmp;
    int n_fail;

    logic [11:0] cap_x;
    logic [11:0] cap_y;
    logic [2:0]  cap_rgb;
    logic        cap_start;
    logic        cap_fd;
    logic        cap_start_after;
    logic        cap_fd_after;

    typedef struct {
        logic [1:0]  ctl;
        logic [31:0] din;
        logic [11:0] ex;
        logic [11:0] ey;
        logic [2:0]  ergb;
        logic        estart;
        logic        efd;
    } vec_t;

    vec_t vecs[10];

    projector_interface dut (
        .clk        (clk),
        .reset      (reset),
        .update     (update),
        .data_in    (data_in),
        .control    (control),
        .frame_done (frame_done),
        .DAC_x      (DAC_x),
        .DAC_y      (DAC_y),
        .DAC_start  (DAC_start),
        .laser_rgb  (laser_rgb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One update pulse: captures outputs right after the tick edge and one cycle later.
    task automatic pulse(input logic [1:0] c, input logic [31:0] d);
        @(negedge clk);
        control = c;
        data_in = d;
        update  = 1'b1;
        @(posedge clk);
        #1;
        cap_x     = DAC_x;
        cap_y     = DAC_y;
        cap_rgb   = laser_rgb;
        cap_start = DAC_start;
        cap_fd    = frame_done;
        @(negedge clk);
        update = 1'b0;
        @(posedge clk);
        #1;
        cap_start_after = DAC_start;
        cap_fd_after    = frame_done;
    endtask

    // Expected test-square point, straight from the edge/offset definition.
    function automatic logic [26:0] pat_point(input int idx);
        int e;
        int k;
        int x;
        int y;
        logic [2:0] rgb;
        e = idx / 8;
        k = idx % 8;
        case (e)
            0:       begin x = 'h400 + k * 'h100; y = 'h400;           rgb = 3'b100; end
            1:       begin x = 'hC00;           y = 'h400 + k * 'h100; rgb = 3'b010; end
            2:       begin x = 'hC00 - k * 'h100; y = 'hC00;           rgb = 3'b001; end
            default: begin x = 'h400;           y = 'hC00 - k * 'h100; rgb = 3'b111; end
        endcase
        return {12'(x), 12'(y), rgb};
    endfunction

    initial begin
        int cnt;
        logic [26:0] pp;
        n_cmp   = 0;
        n_fail  = 0;
        reset   = 1'b1;
        update  = 1'b0;
        control = 2'd0;
        data_in = 32'h0;

        vecs[0] = '{2'd2, 32'h0000_0000, 12'h400, 12'h400, 3'b100, 1'b1, 1'b0};
        vecs[1] = '{2'd2, 32'hFFFF_FFFF, 12'h500, 12'h400, 3'b100, 1'b1, 1'b0};
        vecs[2] = '{2'd1, 32'h8523_4ABC, 12'hABC, 12'h234, 3'b101, 1'b1, 1'b1};
        vecs[3] = '{2'd1, 32'h0523_4ABC, 12'hABC, 12'h234, 3'b101, 1'b1, 1'b0};
        vecs[4] = '{2'd3, 32'h8523_4ABC, 12'hABC, 12'h234, 3'b000, 1'b1, 1'b1};
        vecs[5] = '{2'd0, 32'h8523_4ABC, 12'h800, 12'h800, 3'b000, 1'b0, 1'b0};
        vecs[6] = '{2'd2, 32'h0000_0000, 12'h400, 12'h400, 3'b100, 1'b1, 1'b0};
        vecs[7] = '{2'd2, 32'h0000_0000, 12'h500, 12'h400, 3'b100, 1'b1, 1'b0};
        vecs[8] = '{2'd1, 32'h7800_0000, 12'h000, 12'h000, 3'b000, 1'b1, 1'b0};
        vecs[9] = '{2'd2, 32'h0000_0000, 12'h400, 12'h400, 3'b100, 1'b1, 1'b0};

        // Reset state, then idle with update low.
        repeat (3) @(posedge clk);
        #1;
        check("rst_x", 32'(DAC_x), 32'h800);
        check("rst_y", 32'(DAC_y), 32'h800);
        check("rst_rgb", 32'(laser_rgb), 32'h0);
        check("rst_start", 32'(DAC_start), 32'h0);
        check("rst_fd", 32'(frame_done), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (DAC_x !== 12'h800 || DAC_y !== 12'h800 || laser_rgb !== 3'b000 ||
                DAC_start !== 1'b0 || frame_done !== 1'b0)
                check("idle", {DAC_x, DAC_y, laser_rgb, DAC_start, frame_done}, {12'h800, 12'h800, 3'b000, 1'b0, 1'b0});
            else
                check("idle_start", 32'(DAC_start), 32'h0);
        end

        // Vector table.
        for (int i = 0; i < 10; i++) begin
            pulse(vecs[i].ctl, vecs[i].din);
            check($sformatf("v%0d_x", i), 32'(cap_x), 32'(vecs[i].ex));
            check($sformatf("v%0d_y", i), 32'(cap_y), 32'(vecs[i].ey));
            check($sformatf("v%0d_rgb", i), 32'(cap_rgb), 32'(vecs[i].ergb));
            check($sformatf("v%0d_start", i), 32'(cap_start), 32'(vecs[i].estart));
            check($sformatf("v%0d_fd", i), 32'(cap_fd), 32'(vecs[i].efd));
            check($sformatf("v%0d_start_after", i), 32'(cap_start_after), 32'h0);
            check($sformatf("v%0d_hold_x", i), 32'(DAC_x), 32'(vecs[i].ex));
        end

        // Full square plus wrap; one idle cycle outside mode 2 rewinds the index.
        @(negedge clk);
        control = 2'd0;
        @(negedge clk);
        for (int i = 0; i < 33; i++) begin
            pulse(2'd2, $urandom);
            pp = pat_point(i % 32);
            check($sformatf("sq%0d_x", i), 32'(cap_x), 32'(pp[26:15]));
            check($sformatf("sq%0d_y", i), 32'(cap_y), 32'(pp[14:3]));
            check($sformatf("sq%0d_rgb", i), 32'(cap_rgb), 32'(pp[2:0]));
            check($sformatf("sq%0d_start", i), 32'(cap_start), 32'h1);
            check($sformatf("sq%0d_fd", i), 32'(cap_fd), (i == 31) ? 32'h1 : 32'h0);
            check($sformatf("sq%0d_fd_after", i), 32'(cap_fd_after), 32'h0);
        end
        check("sq_p9", {cap_x, cap_y}, {12'h400, 12'h400});

        // Held update gives exactly one tick; index then advances by one.
        pulse(2'd0, 32'h0);
        @(negedge clk);
        control = 2'd2;
        update  = 1'b1;
        cnt     = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            cnt += int'(DAC_start);
        end
        @(negedge clk);
        update = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            cnt += int'(DAC_start);
        end
        check("hold_pulses", 32'(cnt), 32'h1);
        check("hold_x", 32'(DAC_x), 32'h400);
        pulse(2'd2, 32'h0);
        check("hold_next_x", 32'(cap_x), 32'h500);
        check("hold_next_y", 32'(cap_y), 32'h400);
        pulse(2'd0, 32'h0);
        check("park_x", 32'(cap_x), 32'h800);
        check("park_y", 32'(cap_y), 32'h800);
        check("park_rgb", 32'(cap_rgb), 32'h0);
        check("park_start", 32'(cap_start), 32'h0);

        // Reset mid-frame at point 12.
        @(negedge clk);
        control = 2'd2;
        @(negedge clk);
        for (int i = 0; i < 13; i++) pulse(2'd2, 32'h0);
        check("mid_x", 32'(cap_x), 32'hC00);
        check("mid_y", 32'(cap_y), 32'h800);
        check("mid_rgb", 32'(cap_rgb), 32'h2);
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("mid_rst_x", 32'(DAC_x), 32'h800);
        check("mid_rst_y", 32'(DAC_y), 32'h800);
        check("mid_rst_rgb", 32'(laser_rgb), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        pulse(2'd2, 32'h0);
        check("post_rst_x", 32'(cap_x), 32'h400);
        check("post_rst_y", 32'(cap_y), 32'h400);
        check("post_rst_start", 32'(cap_start), 32'h1);

        // Update already high when reset releases ticks on the first clock.
        @(negedge clk);
        reset   = 1'b1;
        update  = 1'b1;
        control = 2'd1;
        data_in = 32'h0612_3456;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("rel_start", 32'(DAC_start), 32'h1);
        check("rel_x", 32'(DAC_x), 32'h456);
        check("rel_y", 32'(DAC_y), 32'h123);
        check("rel_rgb", 32'(laser_rgb), 32'h6);
        @(posedge clk);
        #1;
        check("rel_start_after", 32'(DAC_start), 32'h0);
        update = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
